vk_clock_sync_filt: RTL and testbench

Multi-channel successor to the basic synchroniser chain. Each channel has a DEPTH-stage metastability chain, then a stability (debounce) filter, then registered rise/fall pulse generation. The block sits at the destination-domain boundary for asynchronous control inputs such as buttons, status lines and slow flags. Downstream logic gets glitch-free levels plus single-cycle edge events.

---
 rtl/vk_sync_pkg.sv | 16 +
 rtl/vk_sync_filter_ch.sv | 78 +++++++
 rtl/vk_clock_sync_filt.sv | 46 ++++
 tb/tb_vk_clock_sync_filt.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vk_sync_pkg.sv
// Shared types and helpers for the multi-channel synchroniser/debounce block.
package vk_sync_pkg;

   localparam int GLITCH_CNT_W = 8;

   function automatic int cnt_width(input int len);
      return (len < 1) ? 1 : $clog2(len + 1);
   endfunction

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } ch_status_t;

endpackage

// File: rtl/vk_sync_filter_ch.sv
// One channel: metastability chain, stability filter, registered edge pulses.
// Optional reject counter when VK_SYNC_GLITCH_CNT_EN is defined.
module vk_sync_filter_ch
   import vk_sync_pkg::*;
#(
   parameter int   DEPTH      = 2,
   parameter int   FILTER_LEN = 4,
   parameter logic INIT_VAL   = 1'b0
) (
   input  logic                    dst_clk,
   input  logic                    rstn,
   input  logic                    din,
`ifdef VK_SYNC_GLITCH_CNT_EN
   input  logic                    glitch_clr,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
   output ch_status_t              status
);

   localparam int             CW       = cnt_width(FILTER_LEN);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

   (* ASYNC_REG = "TRUE", shreg_extract = "NO" *) logic [DEPTH-1:0] chain;

   logic          s;
   logic          level;
   logic          rise;
   logic          fall;
   logic [CW-1:0] cnt;

   assign s = chain[DEPTH-1];

   // A reversal while counting restarts the count from zero.
   always_ff @(posedge dst_clk) begin
      if (!rstn) begin
         chain <= {DEPTH{INIT_VAL}};
         level <= INIT_VAL;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[DEPTH-2:0], din};
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (s == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= s;
            cnt   <= '0;
            rise  <= s;
            fall  <= ~s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef VK_SYNC_GLITCH_CNT_EN
   logic reject;

   assign reject = (s == level) && (cnt != '0);

   always_ff @(posedge dst_clk) begin
      if (!rstn) begin
         glitch_cnt <= '0;
      end else if (glitch_clr) begin
         glitch_cnt <= '0;
      end else if (reject && (glitch_cnt != '1)) begin
         glitch_cnt <= glitch_cnt + 1'b1;
      end
   end
`endif

   assign status.level = level;
   assign status.rise  = rise;
   assign status.fall  = fall;

endmodule

// File: rtl/vk_clock_sync_filt.sv
// Multi-channel synchroniser with debounce filter and rise/fall pulses.
// Define VK_SYNC_GLITCH_CNT_EN to add per-channel glitch reject counters.
module vk_clock_sync_filt
   import vk_sync_pkg::*;
#(
   parameter int                  CHANNELS   = 4,
   parameter int                  DEPTH      = 2,
   parameter int                  FILTER_LEN = 4,
   parameter logic [CHANNELS-1:0] INIT_VAL   = '0
) (
   input  logic                             dst_clk,
   input  logic                             rstn,
   input  logic [CHANNELS-1:0]              din,
`ifdef VK_SYNC_GLITCH_CNT_EN
   input  logic                             glitch_clr,
   output logic [CHANNELS*GLITCH_CNT_W-1:0] glitch_cnt,
`endif
   output logic [CHANNELS-1:0]              dout,
   output logic [CHANNELS-1:0]              rise,
   output logic [CHANNELS-1:0]              fall
);

   ch_status_t status [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      vk_sync_filter_ch #(
         .DEPTH      (DEPTH),
         .FILTER_LEN (FILTER_LEN),
         .INIT_VAL   (INIT_VAL[i])
      ) u_ch (
         .dst_clk    (dst_clk),
         .rstn       (rstn),
         .din        (din[i]),
`ifdef VK_SYNC_GLITCH_CNT_EN
         .glitch_clr (glitch_clr),
         .glitch_cnt (glitch_cnt[i*GLITCH_CNT_W +: GLITCH_CNT_W]),
`endif
         .status     (status[i])
      );

      assign dout[i] = status[i].level;
      assign rise[i] = status[i].rise;
      assign fall[i] = status[i].fall;
   end

endmodule

// File: tb/tb_vk_clock_sync_filt.sv
// Randomised and directed bench for vk_clock_sync_filt against a window-based model.
module tb_vk_clock_sync_filt;

   logic        dst_clk = 1'b0;
   logic        rstn    = 1'b0;
   logic [3:0]  din     = 4'b1010;
   logic        glitch_clr = 1'b0;

   logic [3:0]  dout_a, rise_a, fall_a;
   logic [3:0]  dout_b, rise_b, fall_b;
   logic [3:0]  dout_c, rise_c, fall_c;
   logic [31:0] gc_a, gc_b, gc_c;

   int checks = 0;
   int errors = 0;

   always #5 dst_clk = ~dst_clk;

   vk_clock_sync_filt #(.CHANNELS(4), .DEPTH(2), .FILTER_LEN(4), .INIT_VAL(4'b1010)) u_a (
      .dst_clk(dst_clk), .rstn(rstn), .din(din),
`ifdef VK_SYNC_GLITCH_CNT_EN
      .glitch_clr(glitch_clr), .glitch_cnt(gc_a),
`endif
      .dout(dout_a), .rise(rise_a), .fall(fall_a));

   vk_clock_sync_filt #(.CHANNELS(4), .DEPTH(3), .FILTER_LEN(1), .INIT_VAL(4'b1010)) u_b (
      .dst_clk(dst_clk), .rstn(rstn), .din(din),
`ifdef VK_SYNC_GLITCH_CNT_EN
      .glitch_clr(glitch_clr), .glitch_cnt(gc_b),
`endif
      .dout(dout_b), .rise(rise_b), .fall(fall_b));

   vk_clock_sync_filt #(.CHANNELS(4), .DEPTH(2), .FILTER_LEN(2), .INIT_VAL(4'b0000)) u_c (
      .dst_clk(dst_clk), .rstn(rstn), .din(din),
`ifdef VK_SYNC_GLITCH_CNT_EN
      .glitch_clr(glitch_clr), .glitch_cnt(gc_c),
`endif
      .dout(dout_c), .rise(rise_c), .fall(fall_c));

`ifndef VK_SYNC_GLITCH_CNT_EN
   assign gc_a = '0;
   assign gc_b = '0;
   assign gc_c = '0;
`endif

   // Model: dout flips once the last FILTER_LEN synced samples all differ from it.
   int         dep [3]    = '{2, 3, 2};
   int         flen [3]   = '{4, 1, 2};
   logic [3:0] init_v [3] = '{4'b1010, 4'b1010, 4'b0000};
   logic [3:0] din_hist [$];
   int         kcount;
   logic [3:0] dout_m [3];
   logic [3:0] rise_m [3];
   logic [3:0] fall_m [3];
   int         g_m [3][4];

   function automatic logic s_at(input int n, input int j, input int c);
      if (j - dep[n] >= 1) return din_hist[j - dep[n] - 1][c];
      return init_v[n][c];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(posedge dst_clk) begin
      logic       rstn_s, clr_s, ok, rej;
      logic [3:0] din_s;
      logic [3:0] ad [3], ar [3], af [3];
      logic [31:0] ag [3];
      rstn_s = rstn;
      clr_s  = glitch_clr;
      din_s  = din;
      if (!rstn_s) begin
         kcount = 0;
         din_hist.delete();
         for (int n = 0; n < 3; n++) begin
            dout_m[n] = init_v[n];
            rise_m[n] = '0;
            fall_m[n] = '0;
            for (int c = 0; c < 4; c++) g_m[n][c] = 0;
         end
      end else begin
         kcount++;
         din_hist.push_back(din_s);
         for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 4; c++) begin
               ok = (kcount >= flen[n]);
               if (ok)
                  for (int j = kcount - flen[n] + 1; j <= kcount; j++)
                     if (s_at(n, j, c) == dout_m[n][c]) ok = 1'b0;
               rej = (kcount >= 2) && (s_at(n, kcount - 1, c) != dout_m[n][c])
                     && (s_at(n, kcount, c) == dout_m[n][c]);
               if (clr_s) g_m[n][c] = 0;
               else if (rej && g_m[n][c] < 255) g_m[n][c]++;
               rise_m[n][c] = ok && !dout_m[n][c];
               fall_m[n][c] = ok && dout_m[n][c];
               if (ok) dout_m[n][c] = ~dout_m[n][c];
            end
         end
      end
      #1;
      ad = '{dout_a, dout_b, dout_c};
      ar = '{rise_a, rise_b, rise_c};
      af = '{fall_a, fall_b, fall_c};
      ag = '{gc_a, gc_b, gc_c};
      for (int n = 0; n < 3; n++) begin
         chk($sformatf("dout[%0d]", n), {28'd0, ad[n]}, {28'd0, dout_m[n]});
         chk($sformatf("rise[%0d]", n), {28'd0, ar[n]}, {28'd0, rise_m[n]});
         chk($sformatf("fall[%0d]", n), {28'd0, af[n]}, {28'd0, fall_m[n]});
`ifdef VK_SYNC_GLITCH_CNT_EN
         chk($sformatf("glitch_cnt[%0d]", n), ag[n],
             {g_m[n][3][7:0], g_m[n][2][7:0], g_m[n][1][7:0], g_m[n][0][7:0]});
`else
         if (ag[n] != 32'd0) $display("note: unexpected glitch tie-off value");
`endif
      end
   end

   task automatic negs(input int n);
      repeat (n) @(negedge dst_clk);
   endtask

   task automatic after_pos(input int n);
      repeat (n) @(posedge dst_clk);
      #2;
   endtask

   initial begin
      // Reset held 5 cycles with din equal to INIT_VAL, then quiet release.
      negs(5);
      chk("reset_dout", {28'd0, dout_a}, 32'h0000_000a);
      rstn = 1'b1;
      negs(8);
      chk("release_quiet", {24'd0, rise_a, fall_a}, 32'd0);

      // Single rising step on ch0: dout at edge DEPTH+FILTER_LEN.
      din[0] = 1'b1;
      after_pos(5);
      chk("step_edge5", {31'd0, dout_a[0]}, 32'd0);
      after_pos(1);
      chk("step_edge6", {28'd0, dout_a}, 32'h0000_000b);
      chk("step_rise", {24'd0, rise_a, fall_a}, 32'h0000_0010);
      after_pos(1);
      chk("step_rise_1cyc", {28'd0, rise_a}, 32'd0);
      negs(4);

      // Three-cycle glitch on ch1 must be rejected.
      din[1] = 1'b0;
      negs(3);
      din[1] = 1'b1;
      negs(8);
      chk("glitch_dout", {28'd0, dout_a}, 32'h0000_000b);
`ifdef VK_SYNC_GLITCH_CNT_EN
      chk("glitch_cnt_ch1", {24'd0, gc_a[15:8]}, 32'd1);
      glitch_clr = 1'b1;
      negs(1);
      glitch_clr = 1'b0;
      chk("glitch_clr", gc_a, 32'd0);
`endif

      // Simultaneous fall on ch2 and rise on ch3.
      din[3:2] = 2'b01;
      negs(10);
      din[3:2] = 2'b10;
      after_pos(6);
      chk("simul_rise", {28'd0, rise_a}, 32'h0000_0008);
      chk("simul_fall", {28'd0, fall_a}, 32'h0000_0004);
      negs(6);

      // Reset while ch0 is mid-count; release needs full latency again.
      din[0] = 1'b0;
      negs(4);
      rstn = 1'b0;
      din[0] = 1'b1;
      after_pos(1);
      chk("midreset_dout", {28'd0, dout_a}, 32'h0000_000a);
      negs(1);
      rstn = 1'b1;
      after_pos(5);
      chk("midreset_edge5", {31'd0, dout_a[0]}, 32'd0);
      after_pos(1);
      chk("midreset_edge6", {31'd0, dout_a[0]}, 32'd1);
      chk("midreset_rise", {28'd0, rise_a}, 32'd1);
      negs(6);

      // DEPTH=3, FILTER_LEN=1 step: dout changes at edge 4.
      din[0] = 1'b0;
      after_pos(3);
      chk("d3f1_edge3", {31'd0, dout_b[0]}, 32'd1);
      after_pos(1);
      chk("d3f1_edge4", {31'd0, dout_b[0]}, 32'd0);
      chk("d3f1_fall", {28'd0, fall_b}, 32'd1);
      negs(6);

      // 300 single-cycle glitches on ch0 saturate the FILTER_LEN=2 counter.
      for (int i = 0; i < 300; i++) begin
         din[0] = 1'b1;
         negs(1);
         din[0] = 1'b0;
         negs(1);
      end
      negs(4);
`ifdef VK_SYNC_GLITCH_CNT_EN
      chk("glitch_sat", {24'd0, gc_c[7:0]}, 32'd255);
`endif

      // Randomised slow-toggle traffic with occasional reset and clear.
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) din[b] = ~din[b];
         rstn       = ($urandom_range(0, 399) != 0);
         glitch_clr = ($urandom_range(0, 99) == 0);
         negs(1);
      end
      rstn = 1'b1;
      glitch_clr = 1'b0;
      negs(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
